// File: rtl/bj_defs.sv
// Shared command and game-phase encodings for the blackjack
// front end, plus the phase legality rule for player actions.
package bj_defs;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_DEAL  = 2'd1,
    CMD_HIT   = 2'd2,
    CMD_STAND = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    PHASE_IDLE   = 2'd0,
    PHASE_PLAYER = 2'd1,
    PHASE_DEALER = 2'd2,
    PHASE_RESULT = 2'd3
  } phase_e;

  typedef enum logic {
    LK_ARMED  = 1'b0,
    LK_LOCKED = 1'b1
  } lock_e;

  function automatic logic cmd_legal(
    input cmd_e   c,
    input phase_e p
  );
    case (c)
      CMD_DEAL:
        return (p == PHASE_IDLE) ||
               (p == PHASE_RESULT);
      CMD_HIT, CMD_STAND:
        return (p == PHASE_PLAYER);
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO: push/pop with flush override, head word
// presented as NONE whenever the queue is empty.
module cmd_fifo
  import bj_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  cmd_e                   i_din,
  output cmd_e                   o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  cmd_e          r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_count = r_cnt;
  assign o_dout  = o_empty ? CMD_NONE : r_mem[r_rd];

  // a pop frees the slot a full-queue push lands in
  assign w_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_push = i_push & ~i_flush &
                  (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/player_action_queue.sv
// Button front end: sync, edge detect, post-press lockout,
// arbitration and phase filtering feeding a command FIFO.
module player_action_queue
  import bj_defs::*;
#(
  parameter int DEPTH          = 4,
  parameter int LOCKOUT_CYCLES = 1000000,
  parameter int LOCK_W         = 20
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   deal_btn,
  input  logic                   hit_btn,
  input  logic                   stand_btn,
  input  logic [1:0]             game_phase,
  input  logic                   flush,
  input  logic                   cmd_ready,
  output logic                   cmd_valid,
  output logic [1:0]             cmd_code,
  output logic                   drop_pulse,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam logic [LOCK_W-1:0] LOCK_LOAD =
    LOCK_W'(LOCKOUT_CYCLES - 1);

  // bit order {stand, hit, deal}
  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_prev;
  logic [2:0]        r_edge;
  lock_e             r_state;
  logic [LOCK_W-1:0] r_cnt;
  logic              r_drop;

  cmd_e w_win;
  cmd_e w_head;
  logic w_fire;
  logic w_multi;
  logic w_legal;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_full;
  logic w_empty;

  // ones at reset so a held button yields no edge
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_edge  <= '0;
    end else begin
      r_sync1 <= {stand_btn, hit_btn, deal_btn};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
    end
  end

  always_comb begin
    w_win = CMD_NONE;
    priority case (1'b1)
      r_edge[2]: w_win = CMD_STAND;
      r_edge[1]: w_win = CMD_HIT;
      r_edge[0]: w_win = CMD_DEAL;
      default:   w_win = CMD_NONE;
    endcase
  end

  assign w_fire  = (|r_edge) & (r_state == LK_ARMED);
  assign w_multi = |(r_edge & (r_edge - 3'd1));
  assign w_legal = cmd_legal(w_win, phase_e'(game_phase));
  assign w_pop   = cmd_valid & cmd_ready;
  assign w_push  = w_fire & w_legal & ~flush;
  assign w_drop  = w_fire &
                   (w_multi | ~w_legal |
                    (w_full & ~w_pop & ~flush));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= LK_ARMED;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop;
      unique case (r_state)
        LK_ARMED: begin
          if (|r_edge) begin
            r_state <= LK_LOCKED;
            r_cnt   <= LOCK_LOAD;
          end
        end
        LK_LOCKED: begin
          if (r_cnt == '0) r_state <= LK_ARMED;
          else             r_cnt   <= r_cnt - 1'b1;
        end
      endcase
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLOCK_50),
    .i_rst_n (resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_din   (w_win),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (queue_count)
  );

  assign cmd_valid  = ~w_empty;
  assign cmd_code   = w_head;
  assign drop_pulse = r_drop;

endmodule

// File: tb/tb_player_action_queue.sv
// Bench for player_action_queue: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_player_action_queue;

  localparam int DEPTH = 4;
  localparam int LOCK  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       deal = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic [1:0] phase = 2'd0;
  logic       flush = 1'b0;
  logic       ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       drop_pulse;
  logic [2:0] queue_count;

  int total = 0;
  int bad = 0;

  player_action_queue #(
    .DEPTH          (DEPTH),
    .LOCKOUT_CYCLES (LOCK),
    .LOCK_W         (20)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (rst_n),
    .deal_btn    (deal),
    .hit_btn     (hit),
    .stand_btn   (stand),
    .game_phase  (phase),
    .flush       (flush),
    .cmd_ready   (ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .drop_pulse  (drop_pulse),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  // reference model: sampled-button history, queue, lockout end
  int         mq[$];
  logic [4:0] hd = '1;
  logic [4:0] hh = '1;
  logic [4:0] hs = '1;
  int         cyc_n = 0;
  int         lock_end = 0;
  logic       m_drop = 1'b0;
  int         ned;
  int         wc;
  logic       ed, eh, es, lg, mpop, mpush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      hd = '1; hh = '1; hs = '1;
      lock_end = 0;
      m_drop = 1'b0;
    end else begin
      cyc_n++;
      hd = {hd[3:0], deal};
      hh = {hh[3:0], hit};
      hs = {hs[3:0], stand};
      ed = hd[3] & ~hd[4];
      eh = hh[3] & ~hh[4];
      es = hs[3] & ~hs[4];
      ned = int'(ed) + int'(eh) + int'(es);
      mpop = (mq.size() > 0) && ready && !flush;
      mpush = 1'b0;
      m_drop = 1'b0;
      wc = 0;
      if (ned > 0 && cyc_n >= lock_end) begin
        lock_end = cyc_n + LOCK + 1;
        wc = es ? 3 : (eh ? 2 : 1);
        lg = (wc == 1) ? (phase == 2'd0 || phase == 2'd3)
                       : (phase == 2'd1);
        if (ned > 1) m_drop = 1'b1;
        if (!lg) m_drop = 1'b1;
        else if (!flush) begin
          if (mq.size() < DEPTH || mpop) mpush = 1'b1;
          else m_drop = 1'b1;
        end
      end
      if (flush) mq.delete();
      else begin
        if (mpop) void'(mq.pop_front());
        if (mpush) mq.push_back(wc);
      end
    end
  end

  int ev, ec, en;
  always @(negedge clk) begin
    en = mq.size();
    ev = (en > 0) ? 1 : 0;
    ec = (en > 0) ? mq[0] : 0;
    total++;
    if (cmd_valid !== ev[0] || cmd_code !== ec[1:0] ||
        queue_count !== en[2:0] || drop_pulse !== m_drop) begin
      bad++;
      $display("FAIL model t=%0t v=%b/%0d c=%0d/%0d n=%0d/%0d d=%b/%b",
               $time, cmd_valid, ev, cmd_code, ec,
               queue_count, en, drop_pulse, m_drop);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  // one-cycle press; returns just after the edge that acts on it
  task automatic press(input logic [2:0] m);
    {stand, hit, deal} = m;
    cyc(1);
    {stand, hit, deal} = 3'b000;
    cyc(3);
  endtask

  initial begin
    cyc(3);
    chk("rst valid", int'(cmd_valid), 0);
    chk("rst code", int'(cmd_code), 0);
    chk("rst count", int'(queue_count), 0);
    chk("rst drop", int'(drop_pulse), 0);
    rst_n = 1'b1;
    cyc(12);

    // deal held in IDLE: one command after the fixed latency
    phase = 2'd0;
    deal = 1'b1;
    cyc(3);
    chk("t1 early valid", int'(cmd_valid), 0);
    cyc(1);
    chk("t1 valid", int'(cmd_valid), 1);
    chk("t1 code", int'(cmd_code), 1);
    chk("t1 count", int'(queue_count), 1);
    cyc(16);
    deal = 1'b0;
    chk("t1 single", int'(queue_count), 1);
    do_flush();
    chk("t1 flushed", int'(queue_count), 0);
    cyc(10);

    // hit+stand together, then a hit inside lockout
    phase = 2'd1;
    {stand, hit} = 2'b11;
    cyc(4);
    chk("t2 code", int'(cmd_code), 3);
    chk("t2 count", int'(queue_count), 1);
    chk("t2 drop", int'(drop_pulse), 1);
    cyc(1);
    chk("t2 drop once", int'(drop_pulse), 0);
    {stand, hit} = 2'b00;
    cyc(1);
    hit = 1'b1;
    cyc(4);
    chk("t2 locked drop", int'(drop_pulse), 0);
    chk("t2 locked count", int'(queue_count), 1);
    hit = 1'b0;
    do_flush();
    cyc(12);

    // nothing legal in DEALER_TURN
    phase = 2'd2;
    press(3'b010);
    chk("t3 drop", int'(drop_pulse), 1);
    chk("t3 count", int'(queue_count), 0);
    cyc(1);
    chk("t3 drop once", int'(drop_pulse), 0);
    cyc(10);

    // fill to DEPTH with alternating hit/stand, fifth dropped
    phase = 2'd1;
    for (int k = 0; k < 5; k++) begin
      press((k % 2) ? 3'b100 : 3'b010);
      if (k < 4) chk("t4 fill", int'(queue_count), k + 1);
      else begin
        chk("t4 full drop", int'(drop_pulse), 1);
        chk("t4 full count", int'(queue_count), 4);
      end
      cyc(6);
    end
    do_flush();
    cyc(2);
    for (int k = 0; k < 5; k++) begin
      {stand, hit} = (k % 2) ? 2'b10 : 2'b01;
      cyc(1);
      {stand, hit} = 2'b00;
      cyc(2);
      if (k == 4) ready = 1'b1;
      cyc(1);
      if (k == 4) begin
        ready = 1'b0;
        chk("t4 pp count", int'(queue_count), 4);
        chk("t4 pp drop", int'(drop_pulse), 0);
        chk("t4 pp head", int'(cmd_code), 3);
      end
      cyc(6);
    end
    do_flush();
    cyc(10);

    // flush wins over a same-cycle push
    for (int k = 0; k < 3; k++) begin
      press(3'b010);
      cyc(6);
    end
    chk("t5 three", int'(queue_count), 3);
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    cyc(2);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("t5 count", int'(queue_count), 0);
    chk("t5 valid", int'(cmd_valid), 0);
    chk("t5 code", int'(cmd_code), 0);
    chk("t5 drop", int'(drop_pulse), 0);
    cyc(10);

    // stand held across reset release makes nothing
    rst_n = 1'b0;
    stand = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("t6 held", int'(queue_count), 0);
    stand = 1'b0;
    cyc(12);

    // reset in lockout clears all; next press accepted
    {stand, hit} = 2'b11;
    cyc(4);
    {stand, hit} = 2'b00;
    chk("t6 pre drop", int'(drop_pulse), 1);
    chk("t6 pre count", int'(queue_count), 1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst valid", int'(cmd_valid), 0);
    chk("t6 rst code", int'(cmd_code), 0);
    chk("t6 rst count", int'(queue_count), 0);
    chk("t6 rst drop", int'(drop_pulse), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    press(3'b010);
    chk("t6 after count", int'(queue_count), 1);
    chk("t6 after code", int'(cmd_code), 2);
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
